poly_dec_fir_mac: RTL and testbench



---
 rtl/poly_dec_fir_mac_pkg.sv | 17 +
 rtl/poly_dec_fir_mac_if.sv | 28 ++
 rtl/pdf_mac_unit.sv | 20 ++
 rtl/poly_dec_fir_mac.sv | 99 +++++++++
 tb/tb_poly_dec_fir_mac.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/poly_dec_fir_mac_pkg.sv
// poly_dec_pkg: shared state type, width helpers and default parameters for poly_dec_fir_mac
package poly_dec_pkg;
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  localparam int WIN_D = 8;
  localparam int WCOEF_D = 10;
  localparam int TAPS_D = 21;
  localparam int DEC_D = 6;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int acc_w(input int win, input int wcoef, input int taps);
    return win + wcoef + clog2(taps);
  endfunction
endpackage

// File: rtl/poly_dec_fir_mac_if.sv
// poly_dec_fir_mac_if: sample, coefficient and output signals of poly_dec_fir_mac
// master drives x/in_valid/coef_*; slave (the filter) drives in_ready/busy/y/out_valid
interface poly_dec_fir_mac_if
  import poly_dec_pkg::*;
#(
  parameter int WIN = WIN_D,
  parameter int WCOEF = WCOEF_D,
  parameter int TAPS = TAPS_D,
  parameter int OUT_W = acc_w(WIN, WCOEF, TAPS)
);
  logic signed [WIN-1:0] x;
  logic in_valid;
  logic in_ready;
  logic coef_we;
  logic [clog2(TAPS)-1:0] coef_addr;
  logic signed [WCOEF-1:0] coef_data;
  logic busy;
  logic signed [OUT_W-1:0] y;
  logic out_valid;
  modport master (
    output x, in_valid, coef_we, coef_addr, coef_data,
    input in_ready, busy, y, out_valid
  );
  modport slave (
    input x, in_valid, coef_we, coef_addr, coef_data,
    output in_ready, busy, y, out_valid
  );
endinterface

// File: rtl/pdf_mac_unit.sv
// pdf_mac_unit: signed multiply-accumulate with synchronous clear and enable
// ports: clk, rst, clr (acc<=0), en (acc<=acc+a*b), a, b, acc
module pdf_mac_unit #(
  parameter int WA = 8,
  parameter int WB = 10,
  parameter int ACC_W = 23
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic signed [WA-1:0] a,
  input  logic signed [WB-1:0] b,
  output logic signed [ACC_W-1:0] acc
);
  logic signed [WA+WB-1:0] p;
  assign p = a * b;
  always_ff @(posedge clk)
    acc <= (rst || clr) ? '0 : en ? acc + {{(ACC_W-WA-WB){p[WA+WB-1]}}, p} : acc;
endmodule

// File: rtl/poly_dec_fir_mac.sv
// poly_dec_fir_mac: decimate-by-DEC FIR with loadable coefficients on one shared MAC
// ports: clk, reset (sync, active-high), bus (slave: x/in_valid/in_ready, coef_we/coef_addr/coef_data, busy, y/out_valid)
// build option: PDF_ROUND_SAT_EN makes y a rounded (>>> SHIFT) and saturated OUT_W result
module poly_dec_fir_mac
  import poly_dec_pkg::*;
#(
  parameter int WIN = WIN_D,
  parameter int WCOEF = WCOEF_D,
  parameter int TAPS = TAPS_D,
  parameter int DEC = DEC_D,
  parameter int ACC_W = acc_w(WIN, WCOEF, TAPS),
  parameter int SHIFT = 4,
  parameter int OUT_W = ACC_W
) (
  input logic clk,
  input logic reset,
  poly_dec_fir_mac_if.slave bus
);
  localparam int AW = clog2(TAPS);
  localparam int PW = DEC > 1 ? clog2(DEC) : 1;
  if (SHIFT < 1 || TAPS < 2 || TAPS > 256 || DEC < 1 || DEC > TAPS) begin : g_bad_cfg
    $error("poly_dec_fir_mac: parameter out of range");
  end
  logic signed [WIN-1:0] d [TAPS];
  logic signed [WCOEF-1:0] h [TAPS];
  state_t state;
  logic [AW-1:0] k;
  logic [PW-1:0] phase;
  logic signed [ACC_W-1:0] acc;
  logic signed [OUT_W-1:0] y_next;
  logic accept, last, start, coef_ok;
  assign accept = bus.in_valid && state == IDLE;
  assign last = phase == PW'(DEC - 1);
  assign start = accept && last;
  // one extra address bit so an out-of-range index compares correctly when TAPS is a power of two
  assign coef_ok = bus.coef_we && state == IDLE && {1'b0, bus.coef_addr} < (AW + 1)'(TAPS);
  assign bus.in_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  pdf_mac_unit #(.WA(WIN), .WB(WCOEF), .ACC_W(ACC_W)) u_mac (
    .clk(clk),
    .rst(reset),
    .clr(start),
    .en(state == MAC),
    .a(d[k]),
    .b(h[k]),
    .acc(acc)
  );
`ifdef PDF_ROUND_SAT_EN
  localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(1 << (SHIFT - 1));
  localparam logic signed [ACC_W:0] MAXV = (ACC_W + 1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] MINV = -MAXV - 1;
  logic signed [ACC_W:0] rnd;
  // one guard bit keeps the rounding add from wrapping at the top of the accumulator range
  assign rnd = ($signed({acc[ACC_W-1], acc}) + HALF) >>> SHIFT;
  assign y_next = rnd > MAXV ? OUT_W'(MAXV) : rnd < MINV ? OUT_W'(MINV) : OUT_W'(rnd);
`else
  if (OUT_W != ACC_W) begin : g_bad_out_w
    $error("poly_dec_fir_mac: OUT_W must equal ACC_W without rounding");
  end
  assign y_next = acc;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      phase <= '0;
      k <= '0;
      bus.y <= '0;
      bus.out_valid <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        d[i] <= '0;
        h[i] <= '0;
      end
    end else begin
      bus.out_valid <= 1'b0;
      if (coef_ok) h[bus.coef_addr] <= bus.coef_data;
      if (accept) begin
        d[0] <= bus.x;
        for (int i = 1; i < TAPS; i++) d[i] <= d[i-1];
        phase <= last ? '0 : phase + 1'b1;
      end
      case (state)
        IDLE: if (start) begin
          state <= MAC;
          k <= '0;
        end
        MAC: begin
          k <= k + 1'b1;
          if (k == AW'(TAPS - 1)) state <= OUT;
        end
        OUT: begin
          state <= IDLE;
          bus.out_valid <= 1'b1;
          bus.y <= y_next;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_poly_dec_fir_mac.sv
// tb_poly_dec_fir_mac: scoreboard bench for poly_dec_fir_mac (honours PDF_ROUND_SAT_EN)
module tb_poly_dec_fir_mac;
  import poly_dec_pkg::*;
  localparam int WIN = 8;
  localparam int WCOEF = 10;
  localparam int TAPS = 21;
  localparam int DEC = 6;
  localparam int ACC_W = 23;
  localparam int SHIFT = 4;
  localparam int OUT_W = ACC_W;
  localparam int AW = clog2(TAPS);
  logic clk = 1'b0;
  logic reset;
  int vectors = 0;
  int miscompares = 0;
  poly_dec_fir_mac_if #(.WIN(WIN), .WCOEF(WCOEF), .TAPS(TAPS), .OUT_W(OUT_W)) bus ();
  poly_dec_fir_mac #(
    .WIN(WIN), .WCOEF(WCOEF), .TAPS(TAPS), .DEC(DEC),
    .ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic signed [OUT_W-1:0] exp_out(input longint a);
`ifdef PDF_ROUND_SAT_EN
    longint r, mx;
    r = (a + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
    mx = (longint'(1) << (OUT_W - 1)) - 1;
    if (r > mx) r = mx;
    if (r < -mx - 1) r = -mx - 1;
    return OUT_W'(r);
`else
    return OUT_W'(a);
`endif
  endfunction
  int hist [TAPS];
  int hm [TAPS];
  int ph, cnt;
  longint msum;
  logic started = 1'b0;
  logic m_ov, m_ready;
  logic signed [OUT_W-1:0] m_y;
  logic signed [OUT_W-1:0] sb [$];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        hist[i] = 0;
        hm[i] = 0;
      end
      ph = 0;
      cnt = 0;
      sb.delete();
      m_y = '0;
      m_ov = 1'b0;
      m_ready = 1'b1;
      started = 1'b1;
    end else if (started) begin
      m_ov = cnt == 1;
      if (bus.coef_we && cnt == 0 && bus.coef_addr < TAPS) hm[bus.coef_addr] = bus.coef_data;
      if (bus.in_valid && cnt == 0) begin
        for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = bus.x;
        if (ph == DEC - 1) begin
          msum = 0;
          for (int i = 0; i < TAPS; i++) msum += longint'(hm[i]) * longint'(hist[i]);
          sb.push_back(exp_out(msum));
          cnt = TAPS + 1;
        end
        ph = (ph + 1) % DEC;
      end else if (cnt > 0) cnt--;
      m_ready = cnt == 0;
    end
  end
  always @(negedge clk) begin
    if (started && !reset) begin
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_empty: out_valid with y=%0d but none expected", bus.y);
        end else m_y = sb.pop_front();
      end
      vectors++;
      if (bus.out_valid !== m_ov) begin
        miscompares++;
        $display("FAIL out_valid @%0t: got %b want %b", $time, bus.out_valid, m_ov);
      end
      vectors++;
      if (bus.y !== m_y) begin
        miscompares++;
        $display("FAIL y @%0t: got %0d want %0d", $time, bus.y, m_y);
      end
      vectors++;
      if (bus.in_ready !== m_ready) begin
        miscompares++;
        $display("FAIL in_ready @%0t: got %b want %b", $time, bus.in_ready, m_ready);
      end
    end
  end
  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.coef_we = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic load(input int kk, input int v);
    bus.coef_we = 1'b1;
    bus.coef_addr = AW'(kk);
    bus.coef_data = WCOEF'(v);
    @(negedge clk);
    bus.coef_we = 1'b0;
  endtask
  task automatic send(input int xv, input logic we = 1'b0, input int addr = 0, input int data = 0);
    int g;
    bus.x = WIN'(xv);
    bus.in_valid = 1'b1;
    bus.coef_we = we;
    bus.coef_addr = AW'(addr);
    bus.coef_data = WCOEF'(data);
    g = 0;
    while (!bus.in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready stuck at %b, want 1", bus.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.coef_we = 1'b0;
  endtask
  task automatic wait_out(output logic found, output logic signed [OUT_W-1:0] yv);
    found = 1'b0;
    yv = '0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        found = 1'b1;
        yv = bus.y;
      end
    end
  endtask
  task automatic test_reset();
    do_reset();
    vectors += 4;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    if (bus.y !== '0) begin miscompares++; $display("FAIL reset_y: got %0d want 0", bus.y); end
  endtask
  task automatic test_impulse();
    logic f;
    logic signed [OUT_W-1:0] yv, e;
    do_reset();
    for (int i = 0; i < TAPS; i++) load(i, i + 1);
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < DEC; i++) send((g == 0 && i == 0) ? 1 : 0);
      wait_out(f, yv);
      e = exp_out(g < 3 ? 6 * (g + 1) : 0);
      vectors++;
      if (!f || yv !== e) begin miscompares++; $display("FAIL impulse_%0d: got %0d (seen %b) want %0d", g, yv, f, e); end
    end
    bus.in_valid = 1'b0;
  endtask
  task automatic test_dc();
    logic f;
    logic signed [OUT_W-1:0] yv;
    do_reset();
    for (int i = 0; i < TAPS; i++) load(i, 1);
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < DEC; i++) send(127);
      wait_out(f, yv);
    end
    vectors++;
    if (!f || yv !== exp_out(2667)) begin miscompares++; $display("FAIL dc_pos: got %0d want %0d", yv, exp_out(2667)); end
    bus.in_valid = 1'b0;
    for (int i = 0; i < TAPS; i++) load(i, -512);
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < DEC; i++) send(-128);
      wait_out(f, yv);
    end
    vectors++;
    if (!f || yv !== exp_out(1376256)) begin miscompares++; $display("FAIL dc_neg: got %0d want %0d", yv, exp_out(1376256)); end
    bus.in_valid = 1'b0;
  endtask
  task automatic test_handshake();
    int run, ov;
    do_reset();
    for (int i = 0; i < TAPS; i++) load(i, $urandom_range(0, 1023) - 512);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < DEC; i++) send($urandom_range(0, 255) - 128);
      run = 0;
      ov = 0;
      while (!bus.in_ready && run < 100) begin
        ov += int'(bus.out_valid);
        run++;
        @(negedge clk);
      end
      ov += int'(bus.out_valid);
      vectors += 2;
      if (run != TAPS + 1) begin miscompares++; $display("FAIL hs_ready_low_%0d: got %0d cycles want %0d", r, run, TAPS + 1); end
      if (ov != 1) begin miscompares++; $display("FAIL hs_out_valid_%0d: got %0d pulses want 1", r, ov); end
    end
    bus.in_valid = 1'b0;
  endtask
  task automatic test_coef_rules();
    logic f;
    logic signed [OUT_W-1:0] yv;
    do_reset();
    for (int i = 0; i < DEC; i++) send(1);
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL coef_busy: got %b want 1", bus.busy); end
    load(0, 5);
    load(TAPS, 7);
    wait_out(f, yv);
    for (int i = 0; i < DEC - 1; i++) send(3);
    send(2, 1'b1, 0, 9);
    wait_out(f, yv);
    vectors++;
    if (!f || yv !== exp_out(18)) begin miscompares++; $display("FAIL coef_same_cycle: got %0d want %0d", yv, exp_out(18)); end
    bus.in_valid = 1'b0;
    load(TAPS, 11);
  endtask
  task automatic test_reset_mid();
    logic f;
    logic signed [OUT_W-1:0] yv;
    int ov;
    do_reset();
    for (int i = 0; i < TAPS; i++) load(i, i + 1);
    for (int i = 0; i < DEC; i++) send(1);
    repeat (9) @(negedge clk);
    do_reset();
    ov = 0;
    for (int i = 0; i < 30; i++) begin
      ov += int'(bus.out_valid);
      @(negedge clk);
    end
    vectors += 2;
    if (ov != 0) begin miscompares++; $display("FAIL rst_mid_ov: got %0d pulses want 0", ov); end
    if (bus.y !== '0) begin miscompares++; $display("FAIL rst_mid_y: got %0d want 0", bus.y); end
    load(0, 3);
    for (int i = 0; i < DEC - 1; i++) send(4);
    bus.in_valid = 1'b0;
    repeat (30) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_5acc_busy: got %b want 0", bus.busy); end
    send(7);
    bus.in_valid = 1'b0;
    wait_out(f, yv);
    vectors++;
    if (!f || yv !== exp_out(21)) begin miscompares++; $display("FAIL rst_mid_next: got %0d want %0d", yv, exp_out(21)); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < TAPS; i++) load(i, $urandom_range(0, 1023) - 512);
    for (int i = 0; i < 6 * DEC; i++) send($urandom_range(0, 255) - 128);
    bus.in_valid = 1'b0;
    repeat (30) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL b2b_drain: got %0d pending want 0", sb.size()); end
  endtask
  initial begin
    reset = 1'b1;
    bus.x = '0;
    bus.in_valid = 1'b0;
    bus.coef_we = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    @(negedge clk);
    test_reset();
    test_impulse();
    test_dc();
    test_handshake();
    test_coef_rules();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
